video_timing_gen: RTL and testbench

Parametrised video timing controller that generates horizontal and vertical sync, pixel and line coordinates, and an active-video qualifier for a raster display. It is the successor to the fixed low-resolution timing block. It adds configurable porches, sync widths and polarities, a pixel-enable input for divided pixel clocks, and frame and line strobes. It sits between the pixel clock domain and the pixel source/VGA output stage.

---
 rtl/video_timing_gen.sv | 121 ++++++++++++
 tb/tb_video_timing_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with registered, mutually aligned sync and strobes.
// Optional 16-bit frame counter enabled by defining VTC_FRAME_COUNT_EN.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter bit          H_SYNC_POL = 1'b0,
   parameter bit          V_SYNC_POL = 1'b0,
   parameter int unsigned CW         = 12
) (
   input  logic          clock_in,
   input  logic          reset,
   input  logic          enable,
   output logic          hsync,
   output logic          vsync,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          video_active,
   output logic          sof,
   output logic          eol
`ifdef VTC_FRAME_COUNT_EN
   ,
   output logic [15:0]   frame_count
`endif
);

   localparam logic [31:0] H_TOTAL  = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [31:0] V_TOTAL  = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [31:0] HS_FIRST = 32'(H_ACTIVE + H_FP);
   localparam logic [31:0] HS_LAST  = 32'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [31:0] VS_FIRST = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0] VS_LAST  = 32'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] H_EOL_C    = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] HS_FIRST_C = CW'(HS_FIRST);
   localparam logic [CW-1:0] HS_LAST_C  = CW'(HS_LAST);
   localparam logic [CW-1:0] VS_FIRST_C = CW'(VS_FIRST);
   localparam logic [CW-1:0] VS_LAST_C  = CW'(VS_LAST);

   logic [CW-1:0] hcount_q, hcount_d;
   logic [CW-1:0] vcount_q, vcount_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          active_q, active_d;
   logic          sof_q, sof_d;
   logic          eol_q, eol_d;
   logic          h_wrap;

   // Qualifiers are decoded from the next coordinates so that, once registered,
   // they line up with the coordinates presented in the same cycle.
   always_comb begin
      h_wrap   = (hcount_q == H_LAST_C);
      hcount_d = h_wrap ? '0 : hcount_q + CW'(1);
      vcount_d = vcount_q;
      if (h_wrap) begin
         vcount_d = (vcount_q == V_LAST_C) ? '0 : vcount_q + CW'(1);
      end
      hsync_d  = ((hcount_d >= HS_FIRST_C) && (hcount_d <= HS_LAST_C)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_d  = ((vcount_d >= VS_FIRST_C) && (vcount_d <= VS_LAST_C)) ? V_SYNC_POL : ~V_SYNC_POL;
      active_d = (hcount_d < H_ACT_C) && (vcount_d < V_ACT_C);
      sof_d    = (hcount_d == '0) && (vcount_d == '0);
      eol_d    = (hcount_d == H_EOL_C) && (vcount_d < V_ACT_C);
   end

   // Reset parks the generator on the last pixel of a frame so the first
   // enabled clock lands on (0,0) with sof raised.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         hcount_q <= H_LAST_C;
         vcount_q <= V_LAST_C;
         hsync_q  <= ~H_SYNC_POL;
         vsync_q  <= ~V_SYNC_POL;
         active_q <= 1'b0;
         sof_q    <= 1'b0;
         eol_q    <= 1'b0;
      end else if (enable) begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         active_q <= active_d;
         sof_q    <= sof_d;
         eol_q    <= eol_d;
      end else begin
         sof_q    <= 1'b0;
         eol_q    <= 1'b0;
      end
   end

`ifdef VTC_FRAME_COUNT_EN
   logic [15:0] frame_count_q;

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         frame_count_q <= 16'hFFFF;
      end else if (enable && sof_d) begin
         frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign frame_count = frame_count_q;
`endif

   assign hcount       = hcount_q;
   assign vcount       = vcount_q;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign video_active = active_q;
   assign sof          = sof_q;
   assign eol          = eol_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 800x525 instance, an active-high hsync
// instance, and a small-raster instance used for multi-frame, vsync and reset scenarios.
module tb_video_timing_gen;

   logic clk = 1'b0;
   logic en;
   logic b_rst_n;
   logic s_rst_n;

   logic        b_hs, b_vs, b_va, b_sof, b_eol;
   logic [11:0] b_hc, b_vc;
   logic        p_hs, p_vs, p_va, p_sof, p_eol;
   logic [11:0] p_hc, p_vc;
   logic        s_hs, s_vs, s_va, s_sof, s_eol;
   logic [4:0]  s_hc, s_vc;
`ifdef VTC_FRAME_COUNT_EN
   logic [15:0] b_fc, p_fc, s_fc;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   video_timing_gen u_big (
      .clock_in(clk), .reset(b_rst_n), .enable(en),
      .hsync(b_hs), .vsync(b_vs), .hcount(b_hc), .vcount(b_vc),
      .video_active(b_va), .sof(b_sof), .eol(b_eol)
`ifdef VTC_FRAME_COUNT_EN
      , .frame_count(b_fc)
`endif
   );

   video_timing_gen #(.H_SYNC_POL(1'b1)) u_pol (
      .clock_in(clk), .reset(b_rst_n), .enable(en),
      .hsync(p_hs), .vsync(p_vs), .hcount(p_hc), .vcount(p_vc),
      .video_active(p_va), .sof(p_sof), .eol(p_eol)
`ifdef VTC_FRAME_COUNT_EN
      , .frame_count(p_fc)
`endif
   );

   // Small raster: H 6+2+3+2 = 13, V 4+2+2+1 = 9, frame = 117 clocks.
   video_timing_gen #(
      .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(1), .CW(5)
   ) u_small (
      .clock_in(clk), .reset(s_rst_n), .enable(en),
      .hsync(s_hs), .vsync(s_vs), .hcount(s_hc), .vcount(s_vc),
      .video_active(s_va), .sof(s_sof), .eol(s_eol)
`ifdef VTC_FRAME_COUNT_EN
      , .frame_count(s_fc)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int h, v, nsof, last_sof;
      en      = 1'b1;
      b_rst_n = 1'b0;
      s_rst_n = 1'b0;
      repeat (3) step();

      chk("rst_b_hc", b_hc, 799);
      chk("rst_b_vc", b_vc, 524);
      chk("rst_b_hs", b_hs, 1);
      chk("rst_b_vs", b_vs, 1);
      chk("rst_b_va", b_va, 0);
      chk("rst_b_sof", b_sof, 0);
      chk("rst_b_eol", b_eol, 0);
      chk("rst_p_hs", p_hs, 0);
      chk("rst_s_hc", s_hc, 12);
      chk("rst_s_vc", s_vc, 8);
`ifdef VTC_FRAME_COUNT_EN
      chk("rst_b_fc", b_fc, 16'hFFFF);
`endif

      b_rst_n = 1'b1;
      step();
      chk("first_hc", b_hc, 0);
      chk("first_vc", b_vc, 0);
      chk("first_va", b_va, 1);
      chk("first_sof", b_sof, 1);
      chk("first_hs", b_hs, 1);
`ifdef VTC_FRAME_COUNT_EN
      chk("first_fc", b_fc, 0);
`endif

      for (int i = 1; i < 800; i++) begin
         step();
         chk($sformatf("b_hc@%0d", i), b_hc, i);
         chk($sformatf("b_vc@%0d", i), b_vc, 0);
         chk($sformatf("b_va@%0d", i), b_va, (i < 640) ? 1 : 0);
         chk($sformatf("b_eol@%0d", i), b_eol, (i == 639) ? 1 : 0);
         chk($sformatf("b_sof@%0d", i), b_sof, 0);
         chk($sformatf("b_hs@%0d", i), b_hs, (i >= 656 && i <= 751) ? 0 : 1);
         chk($sformatf("p_hs@%0d", i), p_hs, (i >= 656 && i <= 751) ? 1 : 0);
         chk($sformatf("b_vs@%0d", i), b_vs, 1);
      end

      step();
      chk("lwrap_hc", b_hc, 0);
      chk("lwrap_vc", b_vc, 1);
      chk("lwrap_sof", b_sof, 0);
      chk("lwrap_va", b_va, 1);

      repeat (100) step();
      chk("pre_stall_hc", b_hc, 100);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_hc", b_hc, 100);
         chk("stall_vc", b_vc, 1);
         chk("stall_va", b_va, 1);
         chk("stall_hs", b_hs, 1);
         chk("stall_vs", b_vs, 1);
         chk("stall_sof", b_sof, 0);
         chk("stall_eol", b_eol, 0);
      end
      en = 1'b1;
      step();
      chk("post_stall_hc", b_hc, 101);

      repeat (538) step();
      chk("eol_stall_hc", b_hc, 639);
      chk("eol_stall_eol", b_eol, 1);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("eol_hold_hc", b_hc, 639);
         chk("eol_hold_eol", b_eol, 0);
         chk("eol_hold_va", b_va, 1);
      end
      en = 1'b1;
      step();
      chk("eol_resume_hc", b_hc, 640);
      chk("eol_resume_eol", b_eol, 0);
      chk("eol_resume_va", b_va, 0);
      b_rst_n = 1'b0;

      s_rst_n  = 1'b1;
      nsof     = 0;
      last_sof = 0;
      for (int n = 0; n < 351; n++) begin
         step();
         h = n % 13;
         v = (n / 13) % 9;
         chk($sformatf("s_hc@%0d", n), s_hc, h);
         chk($sformatf("s_vc@%0d", n), s_vc, v);
         chk($sformatf("s_va@%0d", n), s_va, (h < 6 && v < 4) ? 1 : 0);
         chk($sformatf("s_eol@%0d", n), s_eol, (h == 5 && v < 4) ? 1 : 0);
         chk($sformatf("s_hs@%0d", n), s_hs, (h >= 8 && h <= 10) ? 0 : 1);
         chk($sformatf("s_vs@%0d", n), s_vs, (v >= 6 && v <= 7) ? 0 : 1);
         chk($sformatf("s_sof@%0d", n), s_sof, (h == 0 && v == 0) ? 1 : 0);
`ifdef VTC_FRAME_COUNT_EN
         chk($sformatf("s_fc@%0d", n), s_fc, n / 117);
`endif
         if (s_sof) begin
            if (nsof > 0) chk("sof_gap", n - last_sof, 117);
            last_sof = n;
            nsof++;
         end
      end
      chk("sof_count", nsof, 3);

      repeat (30) step();
      chk("pre_rst_hc", s_hc, 3);
      chk("pre_rst_vc", s_vc, 2);
      s_rst_n = 1'b0;
      #1;
      chk("async_rst_hc", s_hc, 12);
      chk("async_rst_vc", s_vc, 8);
      chk("async_rst_va", s_va, 0);
      chk("async_rst_hs", s_hs, 1);
      chk("async_rst_vs", s_vs, 1);
      chk("async_rst_sof", s_sof, 0);
      en = 1'b0;
      repeat (2) step();
      chk("rst_hold_hc", s_hc, 12);
      s_rst_n = 1'b1;
      en      = 1'b1;
      step();
      chk("rel_hc", s_hc, 0);
      chk("rel_vc", s_vc, 0);
      chk("rel_sof", s_sof, 1);
      chk("rel_va", s_va, 1);
`ifdef VTC_FRAME_COUNT_EN
      chk("rel_fc", s_fc, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
